// File: rtl/y_pkg.sv
// Shared definitions for the yAlu operand stage: widths, opcode/funct constants,
// ALU op encodings and the decoded operand bundle.
package y_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RA_W  = $clog2(NREGS);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         op;
        logic [RA_W-1:0] rd;
        logic            wen;
        logic            ill;
    } y_bundle_t;

    localparam y_bundle_t BUNDLE_RST = '{
        a:   '0,
        b:   '0,
        op:  ALU_ADD,
        rd:  '0,
        wen: 1'b0,
        ill: 1'b0
    };

endpackage

// File: rtl/y_operand_stage_if.sv
// Instruction-in, writeback and operand-bundle-out signals of the operand stage.
interface y_operand_stage_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [y_pkg::XLEN-1:0]   in_ins;

    logic                     wb_en;
    logic [y_pkg::RA_W-1:0]   wb_rd;
    logic [y_pkg::XLEN-1:0]   wb_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [y_pkg::XLEN-1:0]   out_a;
    logic [y_pkg::XLEN-1:0]   out_b;
    logic [2:0]               out_op;
    logic [y_pkg::RA_W-1:0]   out_rd;
    logic                     out_wen;
    logic                     out_ill;

    modport master (
        output in_valid, in_ins, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_wen, out_ill
    );

    modport slave (
        input  in_valid, in_ins, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_wen, out_ill
    );

endinterface

// File: rtl/y_rf.sv
// 32x32 integer register file: two combinational read ports with writeback
// bypass, one write port, x0 hardwired to zero, asynchronous clear.
module y_rf
    import y_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic [XLEN-1:0] rd1_c,
    output logic [XLEN-1:0] rd2_c,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // A write landing this cycle is visible to the reader in the same cycle
    assign rd1_c = (rs1 == '0)              ? '0 :
                   (we && (wa == rs1))      ? wd : regs[rs1];
    assign rd2_c = (rs2 == '0)              ? '0 :
                   (we && (wa == rs2))      ? wd : regs[rs2];

endmodule

// File: rtl/y_operand_stage.sv
// Decode/operand-fetch stage feeding yAlu: decodes RV32 R/I ALU instructions,
// reads operands and holds the bundle in a valid/ready output register.
module y_operand_stage
    import y_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    y_operand_stage_if.slave  bus
);

    logic [XLEN-1:0] ins;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [XLEN-1:0] imm;
    logic            legal;
    logic            accept;
    logic            q_valid;
    y_bundle_t       dec;
    y_bundle_t       q;

    assign ins    = bus.in_ins;
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm    = {{(XLEN-12){ins[31]}}, ins[31:20]};

    y_rf u_rf (
        .clk   (clk),
        .rst   (rst),
        .rs1   (ins[19:15]),
        .rs2   (ins[24:20]),
        .rd1_c (rv1),
        .rd2_c (rv2),
        .we    (bus.wb_en),
        .wa    (bus.wb_rd),
        .wd    (bus.wb_data)
    );

    // Unsupported encodings still travel downstream, flagged and with zero operands
    always_comb begin
        legal  = 1'b0;
        dec    = BUNDLE_RST;
        dec.rd = ins[11:7];
        dec.ill = 1'b1;
        case (opcode)
            OP_R: begin
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: begin dec.op = ALU_ADD; legal = 1'b1; end
                    {F7_SUB,  F3_ADD}: begin dec.op = ALU_SUB; legal = 1'b1; end
                    {F7_BASE, F3_AND}: begin dec.op = ALU_AND; legal = 1'b1; end
                    {F7_BASE, F3_OR }: begin dec.op = ALU_OR;  legal = 1'b1; end
                    {F7_BASE, F3_SLT}: begin dec.op = ALU_SLT; legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_I: begin
                case (f3)
                    F3_ADD: begin dec.op = ALU_ADD; legal = 1'b1; end
                    F3_AND: begin dec.op = ALU_AND; legal = 1'b1; end
                    F3_OR:  begin dec.op = ALU_OR;  legal = 1'b1; end
                    F3_SLT: begin dec.op = ALU_SLT; legal = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (legal) begin
            dec.a   = rv1;
            dec.b   = (opcode == OP_R) ? rv2 : imm;
            dec.wen = (ins[11:7] != '0);
            dec.ill = 1'b0;
        end else begin
            dec.op = ALU_ADD;
        end
    end

    assign bus.in_ready = !q_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Output pipeline register; holds while stalled, ignoring later writebacks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= BUNDLE_RST;
        end else if (accept) begin
            q_valid <= 1'b1;
            q       <= dec;
        end else if (bus.out_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign bus.out_valid = q_valid;
    assign bus.out_a     = q.a;
    assign bus.out_b     = q.b;
    assign bus.out_op    = q.op;
    assign bus.out_rd    = q.rd;
    assign bus.out_wen   = q.wen;
    assign bus.out_ill   = q.ill;

endmodule

// File: tb/tb_y_operand_stage.sv
// Scoreboard bench for y_operand_stage: expected bundles are predicted at
// acceptance from a register-file model and compared when the DUT presents them.
module tb_y_operand_stage;
    import y_pkg::*;

    logic clk;
    logic rst;
    y_operand_stage_if bus ();

    y_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      checks   = 0;
    int unsigned      failures = 0;
    y_bundle_t        sb [$];
    logic [31:0]      pend [$];
    logic [31:0]      rf_m [32];
    logic             exp_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
        return rf_m[r];
    endfunction

    function automatic y_bundle_t predict(input logic [31:0] ins);
        y_bundle_t   e;
        logic [31:0] v1  = rd_model(ins[19:15]);
        logic [31:0] v2  = rd_model(ins[24:20]);
        logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
        logic        ok  = 1'b1;
        e = '{a: 32'd0, b: 32'd0, op: ALU_ADD, rd: ins[11:7], wen: 1'b0, ill: 1'b1};
        casez (ins)
            32'b0000000_?????_?????_000_?????_0110011: begin e.op = ALU_ADD; e.b = v2; end
            32'b0100000_?????_?????_000_?????_0110011: begin e.op = ALU_SUB; e.b = v2; end
            32'b0000000_?????_?????_111_?????_0110011: begin e.op = ALU_AND; e.b = v2; end
            32'b0000000_?????_?????_110_?????_0110011: begin e.op = ALU_OR;  e.b = v2; end
            32'b0000000_?????_?????_010_?????_0110011: begin e.op = ALU_SLT; e.b = v2; end
            32'b???????_?????_?????_000_?????_0010011: begin e.op = ALU_ADD; e.b = imm; end
            32'b???????_?????_?????_111_?????_0010011: begin e.op = ALU_AND; e.b = imm; end
            32'b???????_?????_?????_110_?????_0010011: begin e.op = ALU_OR;  e.b = imm; end
            32'b???????_?????_?????_010_?????_0010011: begin e.op = ALU_SLT; e.b = imm; end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            e.a   = v1;
            e.wen = (ins[11:7] != 5'd0);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    // One clock: check at the falling edge, then advance through the rising edge
    task automatic cycle();
        logic      acc;
        y_bundle_t e;
        @(negedge clk);
        check_eq("in_ready", 32'(bus.in_ready), 32'(!exp_valid || bus.out_ready));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (bus.out_valid && sb.size() > 0) begin
            e = sb[0];
            check_eq("out_a",   bus.out_a,          e.a);
            check_eq("out_b",   bus.out_b,          e.b);
            check_eq("out_op",  32'(bus.out_op),    32'(e.op));
            check_eq("out_rd",  32'(bus.out_rd),    32'(e.rd));
            check_eq("out_wen", 32'(bus.out_wen),   32'(e.wen));
            check_eq("out_ill", 32'(bus.out_ill),   32'(e.ill));
            if (bus.out_ready) void'(sb.pop_front());
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb.push_back(predict(bus.in_ins));
        @(posedge clk);
        if (bus.wb_en && bus.wb_rd != 5'd0) rf_m[bus.wb_rd] = bus.wb_data;
        if (acc) begin
            exp_valid = 1'b1;
            if (pend.size() > 0) void'(pend.pop_front());
        end else if (bus.out_ready) begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.wb_en     = 1'($urandom_range(0, 1));
                bus.wb_rd     = 5'($urandom_range(0, 7));
                bus.wb_data   = $urandom;
            end
            bus.in_valid = (pend.size() > 0);
            bus.in_ins   = (pend.size() > 0) ? pend[0] : 32'd0;
            cycle();
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  r1  = 5'($urandom_range(0, 7));
        logic [4:0]  r2  = 5'($urandom_range(0, 7));
        logic [11:0] imm = 12'($urandom);
        case ($urandom_range(0, 10))
            0:  return {7'h00, r2, r1, 3'b000, rd, 7'b0110011};
            1:  return {7'h20, r2, r1, 3'b000, rd, 7'b0110011};
            2:  return {7'h00, r2, r1, 3'b111, rd, 7'b0110011};
            3:  return {7'h00, r2, r1, 3'b110, rd, 7'b0110011};
            4:  return {7'h00, r2, r1, 3'b010, rd, 7'b0110011};
            5:  return {imm, r1, 3'b000, rd, 7'b0010011};
            6:  return {imm, r1, 3'b111, rd, 7'b0010011};
            7:  return {imm, r1, 3'b110, rd, 7'b0010011};
            8:  return {imm, r1, 3'b010, rd, 7'b0010011};
            9:  return {7'h00, r2, r1, 3'b001, rd, 7'b0110011};
            default: return {imm, r1, 3'b010, rd, 7'b0000011};
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_op",    32'(bus.out_op),    32'(ALU_ADD));
        check_eq("rst_out_a",     bus.out_a,          32'd0);
        check_eq("rst_out_b",     bus.out_b,          32'd0);
        check_eq("rst_out_rd",    32'(bus.out_rd),    32'd0);
        check_eq("rst_out_wen",   32'(bus.out_wen),   32'd0);
        check_eq("rst_out_ill",   32'(bus.out_ill),   32'd0);
        sb.delete();
        pend.delete();
        exp_valid = 1'b0;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ins    = 32'd0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.out_ready = 1'b1;
        #1;
        apply_reset();
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // read x5 after reset
        pend.push_back(32'h000281B3);
        run(2, 1'b0);

        // writebacks then add x3,x1,x2
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd7;
        run(1, 1'b0);
        bus.wb_rd = 5'd2; bus.wb_data = 32'd5;
        run(1, 1'b0);
        bus.wb_en = 1'b0;
        pend.push_back(32'h002081B3);
        pend.push_back(32'hFFF08213);
        pend.push_back(32'h402081B3);
        run(4, 1'b0);

        // bypass: wb x1=0x55 in the same cycle as add x3,x1,x0
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h55;
        pend.push_back(32'h000081B3);
        run(1, 1'b0);
        bus.wb_rd = 5'd0; bus.wb_data = 32'd9;
        run(1, 1'b0);
        bus.wb_en = 1'b0;
        pend.push_back(32'h000001B3);
        run(2, 1'b0);

        // stall three cycles with input pending, including a writeback mid-stall
        pend.push_back(32'h002081B3);
        pend.push_back(32'h00F0E213);
        pend.push_back(32'h0020F1B3);
        pend.push_back(32'h0020A233);
        bus.out_ready = 1'b1;
        run(1, 1'b0);
        bus.out_ready = 1'b0;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hABCD;
        run(1, 1'b0);
        bus.wb_en = 1'b0;
        run(2, 1'b0);
        bus.out_ready = 1'b1;
        run(6, 1'b0);

        // randomized flow control and writeback traffic
        for (int i = 0; i < 60; i++) pend.push_back(rand_ins());
        for (int i = 0; i < 400 && pend.size() > 0; i++) run(1, 1'b1);
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        run(3, 1'b0);
        check_eq("pend_drained", 32'(pend.size()), 32'd0);

        // illegal instruction, then reset while stalled
        pend.push_back(32'h00000073);
        run(2, 1'b0);
        pend.push_back(32'h002081B3);
        bus.out_ready = 1'b0;
        run(3, 1'b0);
        check_eq("stall_valid_pre_rst", 32'(bus.out_valid), 32'd1);
        apply_reset();
        bus.out_ready = 1'b1;
        pend.push_back(32'h002081B3);
        run(3, 1'b0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
